// File: rtl/data_sync_tx_pkg.sv
// Shared definitions for the data_sync transmit/receive pair.
// Both sides take their state encodings and default sizes from here.
package data_sync_tx_pkg;

    localparam int DEF_BUS_WIDTH  = 8;
    localparam int DEF_NUM_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_ACK_LOW = 2'd2
    } tx_state_e;

endpackage

// File: rtl/data_sync_tx_bit_sync.sv
// Multi-flop level synchronizer for a single control bit.
// The output is the last flop; all flops clear on reset.
module bit_sync #(
    parameter int NUM_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [NUM_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NUM_STAGES-2:0], d};
        end
    end

    assign q = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_tx.sv
// Source side of a four-phase req/ack bus synchronizer.
// A word is held on unsync_bus until the receiver's ack has gone high then low.
module data_sync_tx
    import data_sync_tx_pkg::*;
#(
    parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
    parameter int NUM_STAGES = DEF_NUM_STAGES
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 bus_ack,
    output logic [BUS_WIDTH-1:0] unsync_bus,
    output logic                 bus_enable,
    output logic                 busy
);

    tx_state_e            state_q;
    tx_state_e            state_d;
    logic [BUS_WIDTH-1:0] bus_d;
    logic                 en_d;
    logic                 ack_s;

    bit_sync #(
        .NUM_STAGES(NUM_STAGES)
    ) u_ack_sync (
        .clk(CLK),
        .rst(RST),
        .d  (bus_ack),
        .q  (ack_s)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            unsync_bus <= '0;
            bus_enable <= 1'b0;
        end else begin
            state_q    <= state_d;
            unsync_bus <= bus_d;
            bus_enable <= en_d;
        end
    end

    // The data register only loads in IDLE, so it is frozen for the
    // whole req/ack cycle and the receiver may sample it at any time.
    always_comb begin
        state_d = state_q;
        bus_d   = unsync_bus;
        en_d    = bus_enable;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    bus_d   = in_data;
                    en_d    = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    en_d    = 1'b0;
                    state_d = ST_ACK_LOW;
                end
            end
            ST_ACK_LOW: begin
                if (!ack_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                en_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = ~in_ready;

endmodule
